// File: rtl/rs485_uart_rx.sv
// rs485_uart_rx: RS-485 receive UART, 8 data bits, optional parity,
// local transmit echo suppressed while tx_de is high.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   RO            : transceiver receiver output (idle high)
//   tx_de         : copy of the transceiver driver enable
//   m_axis_*      : byte stream out (tdata, tvalid, tready)
//   frame_err     : 1-cycle pulse, stop bit sampled low
//   parity_err    : 1-cycle pulse, parity mismatch
//   overrun       : 1-cycle pulse, byte dropped because output full
//   busy          : receiver not idle
module rs485_uart_rx #(
  parameter int    CLKS_PER_BIT  = 868,
  parameter string PARITY        = "None",
  parameter int    ECHO_SUPPRESS = 1
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       RO,
  input  logic       tx_de,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
  } state_t;

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam bit USE_PAR = (PARITY != "None");
  localparam bit ODD     = (PARITY == "Odd");
  localparam bit ECHO    = (ECHO_SUPPRESS != 0);

  state_t      state, nxt;
  logic [1:0]  sync;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        par_bad;
  logic        good, good_q;
  logic        ferr, perr;
  logic        abort;
  logic        half_hit, full_hit;

  assign rx_s     = sync[1];
  assign half_hit = (cnt == HALF_M1);
  assign full_hit = (cnt == FULL_M1);
  // tx_de can only be high outside IDLE if it rose after the frame began
  assign abort    = ECHO && tx_de && (state != S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt  = state;
    good = 1'b0;
    ferr = 1'b0;
    perr = 1'b0;
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:
          if (!(ECHO && tx_de) && !rx_s) nxt = S_START;
        S_START:
          if (half_hit) nxt = rx_s ? S_IDLE : S_DATA;
        S_DATA:
          if (full_hit && bit_idx == 3'd7)
            nxt = USE_PAR ? S_PAR : S_STOP;
        S_PAR:
          if (full_hit) nxt = S_STOP;
        S_STOP:
          if (full_hit) begin
            if (!rx_s) begin
              nxt  = S_BRK;
              ferr = 1'b1;
            end else begin
              nxt  = S_IDLE;
              perr = par_bad;
              good = !par_bad;
            end
          end
        S_BRK:
          if (rx_s) nxt = S_IDLE;
        default:
          nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync    <= 2'b11;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      sync <= {sync[0], RO};
      if (nxt != state || full_hit ||
          state == S_IDLE || state == S_BRK)
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;
      if (state == S_IDLE)
        bit_idx <= '0;
      else if (state == S_DATA && full_hit)
        bit_idx <= bit_idx + 3'd1;
      if (state == S_DATA && full_hit)
        shreg <= {rx_s, shreg[7:1]};
      if (state == S_IDLE)
        par_bad <= 1'b0;
      else if (state == S_PAR && full_hit)
        par_bad <= (((^shreg) ^ rx_s) != ODD);
    end
  end

  // delivery happens one cycle after the stop sample
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      good_q        <= 1'b0;
      frame_err     <= 1'b0;
      parity_err    <= 1'b0;
      overrun       <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      good_q     <= good;
      frame_err  <= ferr;
      parity_err <= perr;
      overrun    <= good_q & m_axis_tvalid;
      if (good_q && !m_axis_tvalid) begin
        m_axis_tdata  <= shreg;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
